// File: rtl/bcd_conv_arbiter_if.sv
// rtl/bcd_conv_arbiter_if.sv - requester, converter and scan-bus signals of the shared BCD converter arbiter
interface bcd_conv_arbiter_if;
  logic       reqA;
  logic [4:0] valA;
  logic       ackA;
  logic       reqB;
  logic [4:0] valB;
  logic       ackB;
  logic [4:0] conv_in;
  logic [3:0] conv_tens;
  logic [3:0] conv_ones;
  logic [7:0] resA;
  logic [7:0] resB;
  logic       busy;
  logic       err;
  logic [3:0] scan_sel;
  logic [3:0] scan_digit;

  modport slave (
    input  reqA, valA, reqB, valB, conv_tens, conv_ones,
    output ackA, ackB, conv_in, resA, resB, busy, err, scan_sel, scan_digit
  );

  modport master (
    output reqA, valA, reqB, valB, conv_tens, conv_ones,
    input  ackA, ackB, conv_in, resA, resB, busy, err, scan_sel, scan_digit
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one binary-to-BCD converter between two requesters
// Holds one result per side and scans the four digits onto a one-hot 7-seg digit bus.
module bcd_conv_arbiter #(
  parameter int SETTLE   = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  bcd_conv_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t     state, state_n;
  logic       ptr, ptr_n;
  logic       gnt, gnt_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] conv_q, conv_n;
  logic [7:0] res_a, res_a_n;
  logic [7:0] res_b, res_b_n;
  logic       ack_a, ack_a_n;
  logic       ack_b, ack_b_n;
  logic       err_q, err_n;
  logic       side;
  logic       granted_req;
  logic [3:0] scan_sel;
  logic [7:0] presc;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt    <= 1'b0;
      cnt    <= 4'd0;
      conv_q <= 5'd0;
      res_a  <= 8'd0;
      res_b  <= 8'd0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      cnt    <= cnt_n;
      conv_q <= conv_n;
      res_a  <= res_a_n;
      res_b  <= res_b_n;
      ack_a  <= ack_a_n;
      ack_b  <= ack_b_n;
      err_q  <= err_n;
    end
  end

  // ptr/gnt encoding: 0 = requester A, 1 = requester B
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    cnt_n       = cnt;
    conv_n      = conv_q;
    res_a_n     = res_a;
    res_b_n     = res_b;
    ack_a_n     = 1'b0;
    ack_b_n     = 1'b0;
    err_n       = err_q;
    side        = (bus.reqA && bus.reqB) ? ptr : bus.reqB;
    granted_req = gnt ? bus.reqB : bus.reqA;
    case (state)
      IDLE: begin
        if (bus.reqA || bus.reqB) begin
          gnt_n   = side;
          conv_n  = side ? bus.valB : bus.valA;
          cnt_n   = CNT_INIT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (!granted_req) begin
          state_n = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          if (gnt) begin
            res_b_n = {bus.conv_tens, bus.conv_ones};
            ack_b_n = 1'b1;
          end else begin
            res_a_n = {bus.conv_tens, bus.conv_ones};
            ack_a_n = 1'b1;
          end
          if (bus.conv_tens > 4'd9 || bus.conv_ones > 4'd9) err_n = 1'b1;
          ptr_n   = ~gnt;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // display scan free-runs regardless of the arbitration state
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      presc    <= 8'd0;
      scan_sel <= 4'b0001;
    end else if (presc == DIV_LAST) begin
      presc    <= 8'd0;
      scan_sel <= {scan_sel[2:0], scan_sel[3]};
    end else begin
      presc    <= presc + 8'd1;
    end
  end

  always_comb begin
    bus.scan_digit = 4'd0;
    case (scan_sel)
      4'b0001: bus.scan_digit = res_a[3:0];
      4'b0010: bus.scan_digit = res_a[7:4];
      4'b0100: bus.scan_digit = res_b[3:0];
      4'b1000: bus.scan_digit = res_b[7:4];
      default: bus.scan_digit = 4'd0;
    endcase
  end

  assign bus.ackA     = ack_a;
  assign bus.ackB     = ack_b;
  assign bus.conv_in  = conv_q;
  assign bus.resA     = res_a;
  assign bus.resB     = res_b;
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err_q;
  assign bus.scan_sel = scan_sel;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - directed self-checking bench for bcd_conv_arbiter
// Two instances share stimulus: settle of 1 cycle for most checks, 3 cycles for latency and abort.
module tb_bcd_conv_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_a, req_b;
  logic [4:0] val_a, val_b;
  logic       bad_conv;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter_if bus1 ();
  bcd_conv_arbiter_if bus3 ();

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    return {4'(v / 5'd10), 4'(v % 5'd10)};
  endfunction

  assign bus1.reqA = req_a;
  assign bus1.reqB = req_b;
  assign bus1.valA = val_a;
  assign bus1.valB = val_b;
  assign {bus1.conv_tens, bus1.conv_ones} = bad_conv ? 8'h0A : to_bcd(bus1.conv_in);
  assign bus3.reqA = req_a;
  assign bus3.reqB = req_b;
  assign bus3.valA = val_a;
  assign bus3.valB = val_b;
  assign {bus3.conv_tens, bus3.conv_ones} = to_bcd(bus3.conv_in);

  bcd_conv_arbiter #(.SETTLE(1), .SCAN_DIV(4)) u_dut1 (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus1.slave)
  );

  bcd_conv_arbiter #(.SETTLE(3), .SCAN_DIV(4)) u_dut3 (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus3.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  logic [3:0] exp_dig [4];
  logic [3:0] prev_sel;
  logic       found;

  initial begin
    exp_dig = '{4'd9, 4'd1, 4'd1, 4'd3};
    rstn = 1'b0; req_a = 1'b0; req_b = 1'b0; val_a = 5'd0; val_b = 5'd0; bad_conv = 1'b0;
    tick();
    tick();
    check("rst_resA", bus1.resA, 8'h00);
    check("rst_resB", bus1.resB, 8'h00);
    check("rst_ack", {bus1.ackA, bus1.ackB}, 2'b00);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_err", bus1.err, 1'b0);
    check("rst_conv_in", bus1.conv_in, 5'd0);
    check("rst_scan_sel", bus1.scan_sel, 4'b0001);
    check("rst_scan_digit", bus1.scan_digit, 4'd0);
    check("rst_busy3", bus3.busy, 1'b0);
    rstn = 1'b1;

    // single A, 5'b10111 = 23
    val_a = 5'b10111; req_a = 1'b1;
    tick();
    check("a_conv_in", bus1.conv_in, 5'd23);
    check("a_busy_g", bus1.busy, 1'b1);
    check("a_ack_g", bus1.ackA, 1'b0);
    tick();
    check("a_ack_g1", bus1.ackA, 1'b1);
    check("a_ackB_g1", bus1.ackB, 1'b0);
    check("a_resA", bus1.resA, 8'h23);
    check("a_busy_g1", bus1.busy, 1'b1);
    req_a = 1'b0;
    tick();
    check("a_ack_g2", bus1.ackA, 1'b0);
    check("a_busy_g2", bus1.busy, 1'b0);

    // contention: A then B then A
    do_reset();
    val_a = 5'd7; val_b = 5'd31; req_a = 1'b1; req_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_ackA_%0d", k), bus1.ackA, (k == 2 || k == 8));
      check($sformatf("rr_ackB_%0d", k), bus1.ackB, (k == 5));
      if (k == 2) check("rr_resA", bus1.resA, 8'h07);
      if (k == 5) check("rr_resB", bus1.resB, 8'h31);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    check("rr_idle", bus1.busy, 1'b0);

    // non-BCD converter result
    do_reset();
    bad_conv = 1'b1; val_a = 5'd1; req_a = 1'b1;
    tick();
    tick();
    check("err_ack", bus1.ackA, 1'b1);
    check("err_resA", bus1.resA, 8'h0A);
    check("err_set", bus1.err, 1'b1);
    req_a = 1'b0; bad_conv = 1'b0;
    tick();
    check("err_sticky", bus1.err, 1'b1);

    // reset during WAIT
    val_a = 5'd4; req_a = 1'b1;
    tick();
    check("mid_busy", bus1.busy, 1'b1);
    rstn = 1'b0;
    tick();
    check("mid_busy_rst", bus1.busy, 1'b0);
    check("mid_ack_rst", bus1.ackA, 1'b0);
    check("mid_err_rst", bus1.err, 1'b0);
    check("mid_resA_rst", bus1.resA, 8'h00);
    rstn = 1'b1; req_a = 1'b0;
    tick();
    check("mid_no_ack", bus1.ackA, 1'b0);

    // settle=3: latency, then aborted B
    do_reset();
    val_a = 5'd5; req_a = 1'b1;
    tick();
    check("s3_busy_g", bus3.busy, 1'b1);
    tick();
    check("s3_ack_g1", bus3.ackA, 1'b0);
    tick();
    check("s3_ack_g2", bus3.ackA, 1'b0);
    tick();
    check("s3_ack_g3", bus3.ackA, 1'b1);
    check("s3_resA", bus3.resA, 8'h05);
    req_a = 1'b0;
    tick();
    check("s3_idle", bus3.busy, 1'b0);
    val_b = 5'd9; req_b = 1'b1;
    tick();
    check("ab_conv_in", bus3.conv_in, 5'd9);
    tick();
    check("ab_busy", bus3.busy, 1'b1);
    req_b = 1'b0;
    tick();
    check("ab_idle", bus3.busy, 1'b0);
    check("ab_no_ack", bus3.ackB, 1'b0);
    check("ab_resB", bus3.resB, 8'h00);
    tick();
    check("ab_no_late_ack", bus3.ackB, 1'b0);
    val_a = 5'd3; val_b = 5'd17; req_a = 1'b1; req_b = 1'b1;
    tick();
    check("ab_ptr_b", bus3.conv_in, 5'd17);
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // scan: resA=19, resB=31
    do_reset();
    val_a = 5'd19; req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    check("sc_resA", bus1.resA, 8'h19);
    tick();
    val_b = 5'd31; req_b = 1'b1;
    tick();
    tick();
    req_b = 1'b0;
    check("sc_resB", bus1.resB, 8'h31);
    tick();
    prev_sel = bus1.scan_sel;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus1.scan_sel == 4'b0001 && prev_sel == 4'b1000) begin
        found = 1'b1;
        break;
      end
      prev_sel = bus1.scan_sel;
    end
    check("sc_wrap_found", found, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sc_sel_%0d", k), bus1.scan_sel, 4'b0001 << (k / 4));
      check($sformatf("sc_digit_%0d", k), bus1.scan_digit, exp_dig[k / 4]);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
